// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter
// Two-port round-robin arbiter in front of a single-ported data memory.
// Port 0 is normally the CPU and port 1 a loader/DMA engine. Each transaction
// takes exactly three cycles: IDLE (grant), ACCESS (memory strobe) and
// DONE (one-cycle ack).
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   req0/1, we0/1            request and write-enable per port
//   addr0/1, wdata0/1        byte address (word aligned) and write data
//   ack0/1, err0/1           completion pulse and reject flag (valid with ack)
//   rdata0/1                 last successful read result per port
//   mem_address, mem_write_data, mem_read, mem_write
//                            memory-side strobes, active only in ACCESS
//   mem_read_data            combinational read data from memory
//   busy                     high whenever a transaction is in flight
module data_mem_arbiter #(
  parameter int ADDR_BITS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic        err0,
  output logic        err1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_read_data,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        grant_q, grant_d;
  logic        lastGrant_q, lastGrant_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        err_q, err_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic [31:0] rdata1_q, rdata1_d;

  logic        pick;
  logic        selWe;
  logic [31:0] selAddr;
  logic [31:0] selWdata;
  logic        selErr;

  // Round-robin choice: on contention the port not granted last wins,
  // otherwise whichever port is requesting alone.
  always_comb begin
    pick     = (req0 && req1) ? ~lastGrant_q : req1;
    selWe    = pick ? we1 : we0;
    selAddr  = pick ? addr1 : addr0;
    selWdata = pick ? wdata1 : wdata0;
    selErr   = (selAddr[1:0] != 2'b00) || ((selAddr >> ADDR_BITS) != 32'd0);
  end

  // State and transaction registers. Reset parks the pointer on port 1 so
  // port 0 wins the first contention.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= 1'b0;
      lastGrant_q <= 1'b1;
      we_q        <= 1'b0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      err_q       <= 1'b0;
      rdata0_q    <= 32'd0;
      rdata1_q    <= 32'd0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      lastGrant_q <= lastGrant_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      err_q       <= err_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
    end
  end

  // Next-state and output decode. Memory strobes are decoded from the
  // registered state so that an asynchronous reset drops them at once.
  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    lastGrant_d    = lastGrant_q;
    we_d           = we_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    err_d          = err_q;
    rdata0_d       = rdata0_q;
    rdata1_d       = rdata1_q;
    ack0           = 1'b0;
    ack1           = 1'b0;
    err0           = 1'b0;
    err1           = 1'b0;
    mem_address    = 32'd0;
    mem_write_data = 32'd0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    busy           = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          state_d = ACCESS;
          grant_d = pick;
          we_d    = selWe;
          addr_d  = selAddr;
          wdata_d = selWdata;
          err_d   = selErr;
        end
      end

      ACCESS: begin
        state_d     = DONE;
        lastGrant_d = grant_q;
        if (!err_q) begin
          mem_address    = addr_q;
          mem_write_data = wdata_q;
          mem_write      = we_q;
          mem_read       = ~we_q;
          if (!we_q) begin
            if (grant_q) begin
              rdata1_d = mem_read_data;
            end else begin
              rdata0_d = mem_read_data;
            end
          end
        end
      end

      DONE: begin
        state_d = IDLE;
        ack0    = ~grant_q;
        ack1    = grant_q;
        err0    = ~grant_q & err_q;
        err1    = grant_q & err_q;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign rdata0 = rdata0_q;
  assign rdata1 = rdata1_q;

endmodule
